cache_port_arb: RTL and testbench

//  Two-master arbiter for the single CPU-side port of the cache (c_addr/c_wr/c_rd/c_wdata/c_bval/c_rdata/c_ack).

---
 rtl/cache_port_arb.sv | 133 +++++++++++++
 tb/tb_cache_port_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arb.sv
// Two-master arbiter for the cache CPU port: registers the winner's request, holds it until c_ack,
// returns read data plus a one-cycle ack to the owner, then idles one cycle; a watchdog flags a missing ack.
module cache_port_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int BW      = 4,
  parameter int RR      = 1,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 200
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wr,
  input  logic          m0_rd,
  input  logic [DW-1:0] m0_wdata,
  input  logic [BW-1:0] m0_bval,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wr,
  input  logic          m1_rd,
  input  logic [DW-1:0] m1_wdata,
  input  logic [BW-1:0] m1_bval,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] c_addr,
  output logic          c_wr,
  output logic          c_rd,
  output logic [DW-1:0] c_wdata,
  output logic [BW-1:0] c_bval,
  input  logic [DW-1:0] c_rdata,
  input  logic          c_ack,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          tmo_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t          state, state_nxt;
  logic            last_m1;
  logic [TMO_W-1:0] wd_cnt;
  logic            req0, req1, pick_m1;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [BW-1:0]   sel_bval;
  logic            sel_wr, sel_rd;

  always_comb begin
    req0      = m0_rd | m0_wr;
    req1      = m1_rd | m1_wr;
    // m1 wins when alone, or on a tie under round-robin if m0 was served last
    pick_m1   = req1 & (~req0 | ((RR != 0) & ~last_m1));
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    sel_bval  = pick_m1 ? m1_bval  : m0_bval;
    sel_wr    = pick_m1 ? m1_wr    : m0_wr;
    sel_rd    = pick_m1 ? m1_rd    : m0_rd;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = BUSY;
      BUSY:    if (c_ack) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      c_addr   <= '0;
      c_wr     <= 1'b0;
      c_rd     <= 1'b0;
      c_wdata  <= '0;
      c_bval   <= '0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      tmo_err  <= 1'b0;
      last_m1  <= 1'b1;
      wd_cnt   <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            c_addr  <= sel_addr;
            c_wdata <= sel_wdata;
            c_bval  <= sel_bval;
            c_wr    <= sel_wr;
            c_rd    <= sel_rd & ~sel_wr;
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            last_m1 <= pick_m1;
          end
        end
        BUSY: begin
          if (c_ack) begin
            c_rd   <= 1'b0;
            c_wr   <= 1'b0;
            grant  <= 2'b00;
            busy   <= 1'b0;
            m0_ack <= grant[0];
            m1_ack <= grant[1];
            wd_cnt <= '0;
            if (c_rd && grant[0]) m0_rdata <= c_rdata;
            if (c_rd && grant[1]) m1_rdata <= c_rdata;
          end else begin
            if (wd_cnt != {TMO_W{1'b1}}) wd_cnt <= wd_cnt + 1'b1;
            // the cycle now ending is the TMO_CYC-th without an ack; the transfer keeps running
            if (wd_cnt >= TMO_LAST) tmo_err <= 1'b1;
          end
        end
        default: wd_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arb.sv
// Bench for cache_port_arb: a round-robin and a fixed-priority instance checked against a transaction-level model.
module tb_cache_port_arb;

  localparam int AW = 16, DW = 32, BW = 4, TMO_CYC = 200;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  logic [AW-1:0] m_addr  [2][2];
  logic          m_wr    [2][2];
  logic          m_rd    [2][2];
  logic [DW-1:0] m_wdata [2][2];
  logic [BW-1:0] m_bval  [2][2];
  logic [DW-1:0] m_rdata [2][2];
  logic          m_ack   [2][2];
  logic [AW-1:0] c_addr  [2];
  logic          c_wr    [2];
  logic          c_rd    [2];
  logic [DW-1:0] c_wdata [2];
  logic [BW-1:0] c_bval  [2];
  logic [DW-1:0] c_rdata [2];
  logic          c_ack   [2];
  logic [1:0]    grant   [2];
  logic          busy    [2];
  logic          tmo_err [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_port_arb #(.AW(AW), .DW(DW), .BW(BW), .RR(g == 0 ? 1 : 0), .TMO_W(8), .TMO_CYC(TMO_CYC)) u_dut (
      .c_clk(c_clk), .reset(reset),
      .m0_addr(m_addr[g][0]), .m0_wr(m_wr[g][0]), .m0_rd(m_rd[g][0]), .m0_wdata(m_wdata[g][0]),
      .m0_bval(m_bval[g][0]), .m0_rdata(m_rdata[g][0]), .m0_ack(m_ack[g][0]),
      .m1_addr(m_addr[g][1]), .m1_wr(m_wr[g][1]), .m1_rd(m_rd[g][1]), .m1_wdata(m_wdata[g][1]),
      .m1_bval(m_bval[g][1]), .m1_rdata(m_rdata[g][1]), .m1_ack(m_ack[g][1]),
      .c_addr(c_addr[g]), .c_wr(c_wr[g]), .c_rd(c_rd[g]), .c_wdata(c_wdata[g]), .c_bval(c_bval[g]),
      .c_rdata(c_rdata[g]), .c_ack(c_ack[g]), .grant(grant[g]), .busy(busy[g]), .tmo_err(tmo_err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // reference model: arbitration policy, last master served, expected read data, sticky timeout
  int            rr_mode [2] = '{1, 0};
  int            last    [2];
  logic [DW-1:0] exp_rd  [2][2];
  bit            sticky  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last[d]   = 1;
      sticky[d] = 1'b0;
      for (int m = 0; m < 2; m++) exp_rd[d][m] = '0;
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      c_ack[d]   = 1'b0;
      c_rdata[d] = '0;
      for (int m = 0; m < 2; m++) begin
        m_rd[d][m] = 1'b0; m_wr[d][m] = 1'b0;
        m_addr[d][m] = '0; m_wdata[d][m] = '0; m_bval[d][m] = '0;
      end
    end
  endtask

  task automatic check_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk("rst_c_addr", c_addr[d], 0);
      chk("rst_c_op", {c_wr[d], c_rd[d]}, 0);
      chk("rst_c_wdata", c_wdata[d], 0);
      chk("rst_c_bval", c_bval[d], 0);
      chk("rst_grant", grant[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_tmo_err", tmo_err[d], 0);
      for (int m = 0; m < 2; m++) begin
        chk("rst_m_rdata", m_rdata[d][m], 0);
        chk("rst_m_ack", m_ack[d][m], 0);
      end
    end
  endtask

  // reset asserted and released off the clock edge; outputs must clear before any edge
  task automatic apply_reset();
    #3;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check_reset_vals();
    tick();
    tick();
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic set_req(input int d, input int m, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [BW-1:0] bv);
    m_rd[d][m] = rd; m_wr[d][m] = wr;
    m_addr[d][m] = a; m_wdata[d][m] = wd; m_bval[d][m] = bv;
  endtask

  // called in an IDLE cycle with at least one request raised; returns in the following IDLE cycle
  task automatic serve(input int d, input int delay, input logic [DW-1:0] rdata, input bit stray);
    int w;
    bit r0, r1, e_wr, e_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_bval;
    r0 = m_rd[d][0] | m_wr[d][0];
    r1 = m_rd[d][1] | m_wr[d][1];
    if (!(r0 || r1)) return;
    if (r0 && r1) w = (rr_mode[d] != 0) ? 1 - last[d] : 0;
    else          w = r0 ? 0 : 1;
    last[d] = w;
    e_wr = m_wr[d][w];
    e_rd = m_rd[d][w] && !m_wr[d][w];
    e_addr = m_addr[d][w]; e_wdata = m_wdata[d][w]; e_bval = m_bval[d][w];

    c_ack[d] = stray;
    tick();
    c_ack[d] = 1'b0;
    chk("grant", grant[d], (w == 0) ? 2'b01 : 2'b10);
    chk("busy", busy[d], 1);
    chk("c_wr", c_wr[d], e_wr);
    chk("c_rd", c_rd[d], e_rd);
    chk("c_addr", c_addr[d], e_addr);
    chk("c_wdata", c_wdata[d], e_wdata);
    chk("c_bval", c_bval[d], e_bval);
    chk("tmo_first", tmo_err[d], sticky[d]);
    for (int m = 0; m < 2; m++) begin
      m_addr[d][m] = AW'($urandom); m_wdata[d][m] = $urandom; m_bval[d][m] = BW'($urandom);
    end
    for (int k = 2; k <= delay; k++) begin
      tick();
      chk("hold_op", {c_wr[d], c_rd[d]}, {e_wr, e_rd});
      chk("hold_addr", c_addr[d], e_addr);
      chk("hold_wdata", c_wdata[d], e_wdata);
      chk("hold_grant", grant[d], (w == 0) ? 2'b01 : 2'b10);
      chk("busy_no_ack", {m_ack[d][1], m_ack[d][0]}, 0);
      chk("tmo_busy", tmo_err[d], sticky[d] || (k - 1 >= TMO_CYC));
    end
    c_ack[d] = 1'b1;
    c_rdata[d] = rdata;
    tick();
    c_ack[d] = stray;
    c_rdata[d] = $urandom;
    if (delay > TMO_CYC) sticky[d] = 1'b1;
    if (e_rd) exp_rd[d][w] = rdata;
    chk("owner_ack", m_ack[d][w], 1);
    chk("other_ack", m_ack[d][1-w], 0);
    chk("rel_grant", grant[d], 0);
    chk("rel_busy", busy[d], 0);
    chk("rel_op", {c_wr[d], c_rd[d]}, 0);
    chk("m0_rdata", m_rdata[d][0], exp_rd[d][0]);
    chk("m1_rdata", m_rdata[d][1], exp_rd[d][1]);
    chk("tmo_rel", tmo_err[d], sticky[d]);
    m_rd[d][w] = 1'b0;
    m_wr[d][w] = 1'b0;
    tick();
    c_ack[d] = 1'b0;
    chk("ack_one_cycle", {m_ack[d][1], m_ack[d][0]}, 0);
    chk("idle_busy", busy[d], 0);
  endtask

  task automatic rand_phase(input int d, input int n);
    bit [1:0] op;
    int m;
    for (int i = 0; i < n; i++) begin
      for (int mm = 0; mm < 2; mm++)
        if (!(m_rd[d][mm] || m_wr[d][mm]) && ($urandom % 2 == 1)) begin
          op = 2'($urandom_range(1, 3));
          set_req(d, mm, op[0], op[1], AW'($urandom), $urandom, BW'($urandom));
        end
      if (!(m_rd[d][0] || m_wr[d][0] || m_rd[d][1] || m_wr[d][1])) begin
        m = $urandom % 2;
        op = 2'($urandom_range(1, 3));
        set_req(d, m, op[0], op[1], AW'($urandom), $urandom, BW'($urandom));
      end
      serve(d, $urandom_range(1, 6), $urandom, 1'($urandom % 2));
    end
    for (int i = 0; i < 2; i++) serve(d, $urandom_range(1, 4), $urandom, 1'b0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals();
    tick();
    #3;
    reset = 1'b0;
    tick();

    // T1: single m0 read, ack after 5 cycles
    set_req(0, 0, 1'b1, 1'b0, 16'h0010, $urandom, 4'hF);
    serve(0, 5, 32'hDEADBEEF, 1'b0);
    chk("t1_rdata", m_rdata[0][0], 32'hDEADBEEF);

    // T2: simultaneous pair straight after reset, then repeated
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 0, 1'b0, 1'b1, AW'($urandom), $urandom, BW'($urandom));
      set_req(0, 1, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
      serve(0, 2, $urandom, 1'b0);
      serve(0, 3, $urandom, 1'b0);
    end

    // T3: both masters requesting continuously, round-robin then fixed priority
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 6; t++) begin
        for (int m = 0; m < 2; m++)
          if (!(m_rd[d][m] || m_wr[d][m]))
            set_req(d, m, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
        serve(d, $urandom_range(1, 4), $urandom, 1'b0);
      end
      if (d == 0) serve(0, 2, $urandom, 1'b0);
      else begin
        chk("t3_fixed_last", last[1], 0);
        m_rd[1][1] = 1'b0;
      end
    end

    // T4: rd and wr together, write wins and rdata stays
    set_req(0, 1, 1'b1, 1'b1, 16'hABC4, 32'h11223344, 4'b0011);
    serve(0, 3, 32'hCAFEF00D, 1'b0);

    // T5: watchdog, late ack still completes, flag stays
    set_req(0, 0, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
    serve(0, 210, 32'h5A5A0001, 1'b0);
    set_req(0, 1, 1'b0, 1'b1, AW'($urandom), $urandom, BW'($urandom));
    serve(0, 2, $urandom, 1'b0);
    chk("t5_sticky", tmo_err[0], 1);

    // T6: reset between edges while BUSY
    set_req(0, 0, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
    tick();
    chk("t6_busy", busy[0], 1);
    tick();
    tick();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      chk("t6_no_ack", {m_ack[0][1], m_ack[0][0]}, 0);
      chk("t6_idle", busy[0], 0);
      tick();
    end
    set_req(0, 1, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
    serve(0, 2, 32'h0BADF00D, 1'b0);
    set_req(0, 0, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
    set_req(0, 1, 1'b1, 1'b0, AW'($urandom), $urandom, BW'($urandom));
    serve(0, 1, $urandom, 1'b0);
    chk("t6_m0_wins", last[0], 0);
    serve(0, 1, $urandom, 1'b0);

    // randomized traffic on both policies
    rand_phase(0, 40);
    rand_phase(1, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
